// File: rtl/vga_pkg.sv
// ----------------------------------------------------------------------------
// vga_pkg
// Shared definitions for the VGA timing generator and output stage.
//   - Default 640x480@60 Hz timing (pixel clock 25 MHz) and the derived
//     totals and active-region start offsets.
//   - Counter and colour widths with matching typedefs.
//   - 12-bit RGB444 colour constants: red in [11:8], green in [7:4],
//     blue in [3:0].
//   - Packed struct that groups the registered pin outputs so they stay
//     aligned with each other.
// ----------------------------------------------------------------------------
package vga_pkg;

    // Widths
    localparam int unsigned CNT_W = 10;   // enough for 0..799 and 0..524
    localparam int unsigned RGB_W = 12;

    typedef logic [CNT_W-1:0] cnt_t;
    typedef logic [RGB_W-1:0] rgb_t;

    // Default 640x480@60 Hz timing.
    // A line runs sync, back porch, display, front porch; count 0 is the
    // first sync cycle. Frames follow the same order in lines.
    localparam int unsigned DEF_H_SYNC  = 96;
    localparam int unsigned DEF_H_BACK  = 48;
    localparam int unsigned DEF_H_DISP  = 640;
    localparam int unsigned DEF_H_FRONT = 16;
    localparam int unsigned DEF_V_SYNC  = 2;
    localparam int unsigned DEF_V_BACK  = 33;
    localparam int unsigned DEF_V_DISP  = 480;
    localparam int unsigned DEF_V_FRONT = 10;
    localparam bit          DEF_SYNC_POL = 1'b0;  // 0: sync pins active-low

    // Derived defaults
    localparam int unsigned DEF_H_TOTAL = DEF_H_SYNC + DEF_H_BACK + DEF_H_DISP + DEF_H_FRONT; // 800
    localparam int unsigned DEF_V_TOTAL = DEF_V_SYNC + DEF_V_BACK + DEF_V_DISP + DEF_V_FRONT; // 525
    localparam int unsigned DEF_H_ACT0  = DEF_H_SYNC + DEF_H_BACK;                            // 144
    localparam int unsigned DEF_V_ACT0  = DEF_V_SYNC + DEF_V_BACK;                            // 35

    // Colour constants (RGB444)
    localparam rgb_t WHITE = 12'hFFF;
    localparam rgb_t BLACK = 12'h000;
    localparam rgb_t RED   = 12'hF00;
    localparam rgb_t GREEN = 12'h0F0;
    localparam rgb_t BLUE  = 12'h00F;

    // Registered pin state; all fields update on the same edge.
    typedef struct packed {
        logic hs;
        logic vs;
        logic de;
        logic frame_start;
        rgb_t rgb;
    } vga_out_t;

endpackage : vga_pkg

// File: rtl/vga_timing_counter.sv
// ----------------------------------------------------------------------------
// vga_timing_counter
// Free-running beam position counters.
//   h_cnt runs 0..H_TOTAL-1 and wraps to 0. v_cnt advances only on the
//   edge where h_cnt wraps, and wraps V_TOTAL-1 -> 0 on that same edge, so
//   the last pixel of the last line rolls both counters to (0,0) together.
//
// Ports
//   clk_25   in   pixel clock
//   rst_n    in   asynchronous active-low reset; counters clear to (0,0)
//   h_cnt_o  out  horizontal position within the line
//   v_cnt_o  out  line number within the frame
// ----------------------------------------------------------------------------
module vga_timing_counter
    import vga_pkg::*;
#(
    parameter int unsigned H_TOTAL = DEF_H_TOTAL,
    parameter int unsigned V_TOTAL = DEF_V_TOTAL
) (
    input  logic clk_25,
    input  logic rst_n,
    output cnt_t h_cnt_o,
    output cnt_t v_cnt_o
);

    localparam cnt_t H_LAST = cnt_t'(H_TOTAL - 1);
    localparam cnt_t V_LAST = cnt_t'(V_TOTAL - 1);

    cnt_t h_cnt_q, h_cnt_d;
    cnt_t v_cnt_q, v_cnt_d;
    logic h_wrap;

    // NOTE: every variable written here gets a value on every path (defaults
    // first), otherwise synthesis infers a latch to hold the old value.
    always_comb begin
        h_wrap  = (h_cnt_q == H_LAST);
        h_cnt_d = h_wrap ? '0 : h_cnt_q + cnt_t'(1);
        v_cnt_d = v_cnt_q;
        if (h_wrap) begin
            v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + cnt_t'(1);
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk_25 or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt_q <= '0;
            v_cnt_q <= '0;
        end else begin
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
        end
    end

    assign h_cnt_o = h_cnt_q;
    assign v_cnt_o = v_cnt_q;

endmodule : vga_timing_counter

// File: rtl/vga_driver.sv
// ----------------------------------------------------------------------------
// vga_driver
// Timing generator and output stage for a VGA port (default 640x480@60 Hz
// at a 25 MHz pixel clock).
//
// The pixel generator upstream is addressed one cycle ahead of the beam:
// the request for column x is issued at h_cnt = H_ACT0-1+x, the generator
// registers its colour on that edge, and the colour is captured into
// vga_rgb on the following edge, landing together with vga_de=1.
//
// Ports
//   clk_25       in   25 MHz pixel clock
//   rst_n        in   asynchronous active-low reset
//   pixel_data   in   12-bit colour, valid one cycle after its request
//   pixel_req    out  combinational: pixel_xpos/ypos address a visible pixel
//   pixel_xpos   out  requested column, 0 when not requesting
//   pixel_ypos   out  requested row, 0 outside active lines
//   vga_hs       out  registered horizontal sync (asserted level SYNC_POL)
//   vga_vs       out  registered vertical sync (asserted level SYNC_POL)
//   vga_de       out  registered data enable (visible region)
//   vga_rgb      out  registered colour to DAC, 0 while blanked
//   frame_start  out  registered one-cycle pulse at the start of each frame
// ----------------------------------------------------------------------------
module vga_driver
    import vga_pkg::*;
#(
    parameter int unsigned H_SYNC   = DEF_H_SYNC,
    parameter int unsigned H_BACK   = DEF_H_BACK,
    parameter int unsigned H_DISP   = DEF_H_DISP,
    parameter int unsigned H_FRONT  = DEF_H_FRONT,
    parameter int unsigned V_SYNC   = DEF_V_SYNC,
    parameter int unsigned V_BACK   = DEF_V_BACK,
    parameter int unsigned V_DISP   = DEF_V_DISP,
    parameter int unsigned V_FRONT  = DEF_V_FRONT,
    parameter bit          SYNC_POL = DEF_SYNC_POL
) (
    input  logic             clk_25,
    input  logic             rst_n,
    input  logic [RGB_W-1:0] pixel_data,
    output logic             pixel_req,
    output logic [CNT_W-1:0] pixel_xpos,
    output logic [CNT_W-1:0] pixel_ypos,
    output logic             vga_hs,
    output logic             vga_vs,
    output logic             vga_de,
    output logic [RGB_W-1:0] vga_rgb,
    output logic             frame_start
);

    // ------------------------------------------------------------------
    // Derived timing, pre-cast to counter width so every compare below is
    // between equal-width operands.
    // ------------------------------------------------------------------
    localparam int unsigned H_TOTAL = H_SYNC + H_BACK + H_DISP + H_FRONT;
    localparam int unsigned V_TOTAL = V_SYNC + V_BACK + V_DISP + V_FRONT;
    localparam int unsigned H_ACT0  = H_SYNC + H_BACK;
    localparam int unsigned V_ACT0  = V_SYNC + V_BACK;

    localparam cnt_t H_SYNC_END = cnt_t'(H_SYNC);
    localparam cnt_t V_SYNC_END = cnt_t'(V_SYNC);
    localparam cnt_t H_VIS0     = cnt_t'(H_ACT0);
    localparam cnt_t H_VIS_END  = cnt_t'(H_ACT0 + H_DISP);
    // Request window is the visible window shifted one cycle earlier.
    localparam cnt_t H_REQ0     = cnt_t'(H_ACT0 - 1);
    localparam cnt_t H_REQ_END  = cnt_t'(H_ACT0 + H_DISP - 1);
    localparam cnt_t V_ACT_BEG  = cnt_t'(V_ACT0);
    localparam cnt_t V_ACT_END  = cnt_t'(V_ACT0 + V_DISP);

    localparam vga_out_t OUT_RST = '{
        hs:          ~SYNC_POL,
        vs:          ~SYNC_POL,
        de:          1'b0,
        frame_start: 1'b0,
        rgb:         BLACK
    };

    // ------------------------------------------------------------------
    // Beam counters
    // ------------------------------------------------------------------
    cnt_t h_cnt;
    cnt_t v_cnt;

    vga_timing_counter #(
        .H_TOTAL (H_TOTAL),
        .V_TOTAL (V_TOTAL)
    ) u_timing_counter (
        .clk_25  (clk_25),
        .rst_n   (rst_n),
        .h_cnt_o (h_cnt),
        .v_cnt_o (v_cnt)
    );

    // ------------------------------------------------------------------
    // Region decode and pixel request (combinational from the counters)
    // ------------------------------------------------------------------
    logic v_act;
    logic h_req_win;
    logic h_vis_win;

    always_comb begin
        v_act      = (v_cnt >= V_ACT_BEG) && (v_cnt < V_ACT_END);
        h_req_win  = (h_cnt >= H_REQ0)    && (h_cnt < H_REQ_END);
        h_vis_win  = (h_cnt >= H_VIS0)    && (h_cnt < H_VIS_END);

        pixel_req  = v_act && h_req_win;
        pixel_xpos = pixel_req ? (h_cnt - H_REQ0)    : '0;
        pixel_ypos = v_act     ? (v_cnt - V_ACT_BEG) : '0;
    end

    // ------------------------------------------------------------------
    // Registered pin stage. Everything here is computed from the current
    // counter state, so all five pins lag the counters by exactly one
    // cycle and stay aligned with each other.
    // ------------------------------------------------------------------
    vga_out_t out_q, out_d;
    logic     de_d;

    always_comb begin
        de_d              = v_act && h_vis_win;
        out_d             = OUT_RST;
        out_d.hs          = (h_cnt < H_SYNC_END) ? SYNC_POL : ~SYNC_POL;
        out_d.vs          = (v_cnt < V_SYNC_END) ? SYNC_POL : ~SYNC_POL;
        out_d.de          = de_d;
        out_d.frame_start = (h_cnt == '0) && (v_cnt == '0);
        // pixel_data arriving now belongs to the request made one cycle
        // ago, i.e. to the pixel this edge puts on the pins. Outside the
        // visible region it is ignored whatever its value.
        out_d.rgb         = de_d ? pixel_data : BLACK;
    end

    always_ff @(posedge clk_25 or negedge rst_n) begin
        if (!rst_n) begin
            out_q <= OUT_RST;
        end else begin
            out_q <= out_d;
        end
    end

    assign vga_hs      = out_q.hs;
    assign vga_vs      = out_q.vs;
    assign vga_de      = out_q.de;
    assign vga_rgb     = out_q.rgb;
    assign frame_start = out_q.frame_start;

endmodule : vga_driver

// File: tb/tb_vga_driver.sv
// ----------------------------------------------------------------------------
// tb_vga_driver
// Self-checking bench for vga_driver. Horizontal timing is the full 800-clock
// line; vertical timing is shortened to 11 lines per frame so that several
// whole frames fit in a short run. Expected values come from a beam-position
// model: n = number of clock edges since reset release, h = n mod 800,
// v = (n div 800) mod 11, with registered pins reflecting position n-1.
// ----------------------------------------------------------------------------
module tb_vga_driver;
    import vga_pkg::*;

    localparam int HS = 96, HB = 48, HD = 640, HF = 16;
    localparam int VS = 2,  VB = 3,  VD = 4,   VF = 2;
    localparam int HT = HS + HB + HD + HF;
    localparam int VT = VS + VB + VD + VF;
    localparam int HA0 = HS + HB;
    localparam int VA0 = VS + VB;
    localparam int FRAME = HT * VT;

    logic        clk_25 = 1'b0;
    logic        rst_n  = 1'b0;
    logic [11:0] pixel_data;
    logic        pixel_req;
    logic [9:0]  pixel_xpos, pixel_ypos;
    logic        vga_hs, vga_vs, vga_de;
    logic [11:0] vga_rgb;
    logic        frame_start;

    vga_driver #(
        .H_SYNC(HS), .H_BACK(HB), .H_DISP(HD), .H_FRONT(HF),
        .V_SYNC(VS), .V_BACK(VB), .V_DISP(VD), .V_FRONT(VF),
        .SYNC_POL(1'b0)
    ) dut (
        .clk_25      (clk_25),
        .rst_n       (rst_n),
        .pixel_data  (pixel_data),
        .pixel_req   (pixel_req),
        .pixel_xpos  (pixel_xpos),
        .pixel_ypos  (pixel_ypos),
        .vga_hs      (vga_hs),
        .vga_vs      (vga_vs),
        .vga_de      (vga_de),
        .vga_rgb     (vga_rgb),
        .frame_start (frame_start)
    );

    always #20 clk_25 = ~clk_25;

    // Pixel generator stub. mode 0: registers {2'b0, xpos} on a request
    // (random junk otherwise); mode 1: constant white; mode 2: random.
    int mode = 1;
    always @(posedge clk_25) begin
        case (mode)
            0:       pixel_data <= pixel_req ? {2'b00, pixel_xpos} : 12'($urandom);
            1:       pixel_data <= WHITE;
            default: pixel_data <= 12'($urandom);
        endcase
    end

    int tests = 0;
    int fails = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Model / tracking state
    int          n;
    logic [11:0] pd_prev;
    int          req_cnt, first_h, last_h, last_x;
    int          hs_low, vs_low, de_cnt, last_fs, fs_total, col;

    task automatic restart_tracking();
        n = 0; req_cnt = 0; first_h = -1; last_h = -1; last_x = -1;
        hs_low = 0; vs_low = 0; de_cnt = 0; last_fs = -1; fs_total = 0; col = 0;
    endtask

    task automatic check_reset_pins(input string where);
        check({where, "_hs"},   32'(vga_hs),      32'd1);
        check({where, "_vs"},   32'(vga_vs),      32'd1);
        check({where, "_de"},   32'(vga_de),      32'd0);
        check({where, "_rgb"},  32'(vga_rgb),     32'd0);
        check({where, "_fs"},   32'(frame_start), 32'd0);
        check({where, "_req"},  32'(pixel_req),   32'd0);
        check({where, "_xpos"}, 32'(pixel_xpos),  32'd0);
        check({where, "_ypos"}, 32'(pixel_ypos),  32'd0);
    endtask

    // Compare the current sample (taken at a negedge) with the model.
    task automatic check_sample();
        int  h, v, p, hp, vp;
        bit  va, ereq, vpa, ede;
        h  = n % HT;
        v  = (n / HT) % VT;
        va = (v >= VA0) && (v < VA0 + VD);
        ereq = va && (h >= HA0 - 1) && (h < HA0 + HD - 1);
        check("pixel_req",  32'(pixel_req),  32'(ereq));
        check("pixel_xpos", 32'(pixel_xpos), ereq ? h - (HA0 - 1) : 0);
        check("pixel_ypos", 32'(pixel_ypos), va ? v - VA0 : 0);

        // Request window summary per line
        if (h == 0) begin
            req_cnt = 0; first_h = -1; last_h = -1; last_x = -1;
        end
        if (pixel_req) begin
            if (first_h < 0) first_h = h;
            last_h = h; last_x = int'(pixel_xpos); req_cnt++;
        end
        if (h == HT - 1) begin
            if (va) begin
                check("line_req_count", req_cnt, HD);
                check("line_req_first_h", first_h, HA0 - 1);
                check("line_req_last_h", last_h, HA0 + HD - 2);
                check("line_req_last_x", last_x, HD - 1);
            end else begin
                check("blank_line_req_count", req_cnt, 0);
            end
        end

        if (n == 0) begin
            check_reset_pins("post_release");
        end else begin
            p  = n - 1;
            hp = p % HT;
            vp = (p / HT) % VT;
            vpa = (vp >= VA0) && (vp < VA0 + VD);
            ede = vpa && (hp >= HA0) && (hp < HA0 + HD);
            check("vga_hs", 32'(vga_hs), (hp < HS) ? 0 : 1);
            check("vga_vs", 32'(vga_vs), (vp < VS) ? 0 : 1);
            check("vga_de", 32'(vga_de), 32'(ede));
            check("frame_start", 32'(frame_start), (p % FRAME == 0) ? 1 : 0);
            check("vga_rgb", 32'(vga_rgb), ede ? 32'(pd_prev) : 0);

            // Aggregate pin statistics over line and frame windows
            if (!vga_hs) hs_low++;
            if (!vga_vs) vs_low++;
            if (vga_de)  de_cnt++;
            if (frame_start) begin
                fs_total++;
                if (last_fs >= 0) check("frame_period", n - last_fs, FRAME);
                last_fs = n;
            end
            if (mode == 0) begin
                if (vga_de) begin
                    check("align_rgb_column", 32'(vga_rgb), col);
                    col++;
                end else begin
                    col = 0;
                end
            end
            if (hp == HT - 1) begin
                check("hs_low_per_line", hs_low, HS);
                hs_low = 0;
            end
            if (p % FRAME == FRAME - 1) begin
                check("vs_low_per_frame", vs_low, VS * HT);
                check("de_per_frame", de_cnt, VD * HD);
                vs_low = 0; de_cnt = 0;
            end
        end
    endtask

    task automatic run_cycles(input int count);
        for (int i = 0; i < count; i++) begin
            @(posedge clk_25);
            n++;
            @(negedge clk_25);
            check_sample();
            pd_prev = pixel_data;
        end
    endtask

    task automatic release_reset();
        @(negedge clk_25);
        rst_n = 1'b1;
        restart_tracking();
        #1;
        check_sample();
        pd_prev = pixel_data;
    endtask

    initial begin
        restart_tracking();
        pd_prev = '0;

        // Reset held with white on pixel_data
        mode  = 1;
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_25);
            check_reset_pins("in_reset");
        end

        // Frame 1: stub generator, alignment of returned columns
        release_reset();
        mode = 0;
        run_cycles(FRAME);

        // Frame 2: constant white, everything outside vga_de must be black
        mode = 1;
        run_cycles(FRAME + 1);

        // Frame 3: random data, then reset in the middle of a visible line
        mode = 2;
        run_cycles(2 * FRAME + 6 * HT + 400 - n);
        check("pre_reset_req", 32'(pixel_req), 32'd1);
        #5 rst_n = 1'b0;
        #1 check_reset_pins("async_reset");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_25);
            check_reset_pins("held_reset");
        end

        // Restart: counters from (0,0), a single frame_start in this frame
        release_reset();
        run_cycles(FRAME - 100);
        check("restart_fs_count", fs_total, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_vga_driver
